// File: rtl/config_pkg.sv
// Shared FP configuration constants.
package config_pkg;
  localparam int unsigned FLEN          = 64;
  localparam bit          ZFH_SUPPORTED = 1'b1;
  localparam bit          D_SUPPORTED   = 1'b1;
  localparam bit          Q_SUPPORTED   = 1'b0;
endpackage

// File: rtl/fli_encode.sv
// Inverse of the Zfa FP immediate load: maps a NaN-boxed FP register value
// to the fli Rs1 index that would produce it. Two-stage valid/ready pipeline.
module fli_encode
  import config_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [FLEN-1:0] X,
  input  logic [1:0]      Fmt,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [4:0]      Idx,
  output logic            Hit,
  output logic            BadBox
);

  typedef enum logic [1:0] {
    FMT_S = 2'b00,
    FMT_D = 2'b01,
    FMT_H = 2'b10,
    FMT_Q = 2'b11
  } fmt_e;

  // Operand is widened so every format's fields can be sliced for any FLEN.
  localparam int unsigned XW = (FLEN > 128) ? FLEN : 128;

  localparam logic H_OK = (ZFH_SUPPORTED != 1'b0) && (FLEN >= 16);
  localparam logic S_OK = (FLEN >= 32);
  localparam logic D_OK = (D_SUPPORTED != 1'b0) && (FLEN >= 64);
  localparam logic Q_OK = (Q_SUPPORTED != 1'b0) && (FLEN >= 128);

  // True when bits [FLEN-1:w] are all ones (or the format fills the register).
  function automatic logic boxed(input logic [XW-1:0] v, input int unsigned w);
    logic [XW-1:0] mask;
    if (w >= FLEN) return 1'b1;
    mask = (XW'(1) << (FLEN - w)) - XW'(1);
    return ((v >> w) & mask) == mask;
  endfunction

  logic [XW-1:0]      xw;
  logic               d_ok, d_box, d_sign, d_half, d_emax, d_ezero, d_rz;
  logic [14:0]        d_ef;
  logic signed [15:0] d_bias, d_exp;
  logic [1:0]         d_m2;

  // Field extraction per format: sign, exponent, top two mantissa bits, rest-zero.
  always_comb begin
    xw      = XW'(X);
    d_ok    = 1'b0;
    d_box   = 1'b1;
    d_sign  = 1'b0;
    d_half  = 1'b0;
    d_emax  = 1'b0;
    d_ezero = 1'b0;
    d_rz    = 1'b0;
    d_ef    = '0;
    d_bias  = '0;
    d_m2    = '0;
    case (fmt_e'(Fmt))
      FMT_H: begin
        d_ok = H_OK; d_half = 1'b1; d_box = boxed(xw, 16);
        d_sign = xw[15]; d_ef = 15'(xw[14:10]); d_bias = 16'sd15;
        d_emax = &xw[14:10]; d_ezero = ~|xw[14:10];
        d_m2 = xw[9:8]; d_rz = ~|xw[7:0];
      end
      FMT_S: begin
        d_ok = S_OK; d_box = boxed(xw, 32);
        d_sign = xw[31]; d_ef = 15'(xw[30:23]); d_bias = 16'sd127;
        d_emax = &xw[30:23]; d_ezero = ~|xw[30:23];
        d_m2 = xw[22:21]; d_rz = ~|xw[20:0];
      end
      FMT_D: begin
        d_ok = D_OK; d_box = boxed(xw, 64);
        d_sign = xw[63]; d_ef = 15'(xw[62:52]); d_bias = 16'sd1023;
        d_emax = &xw[62:52]; d_ezero = ~|xw[62:52];
        d_m2 = xw[51:50]; d_rz = ~|xw[49:0];
      end
      FMT_Q: begin
        d_ok = Q_OK; d_box = boxed(xw, 128);
        d_sign = xw[127]; d_ef = xw[126:112]; d_bias = 16'sd16383;
        d_emax = &xw[126:112]; d_ezero = ~|xw[126:112];
        d_m2 = xw[111:110]; d_rz = ~|xw[109:0];
      end
      default: ;
    endcase
    d_exp = $signed({1'b0, d_ef}) - d_bias;
  end

  logic               s1_valid, s2_valid, s2_load;
  logic               s1_unsup, s1_bad, s1_sign, s1_half, s1_emax, s1_ezero, s1_emin, s1_rz;
  logic signed [15:0] s1_exp;
  logic [1:0]         s1_m2;

  // Stage 2 takes a new entry when empty or draining; stage 1 moves with it.
  assign s2_load  = ~s2_valid | OutReady;
  assign InReady  = ~s1_valid | s2_load;
  assign OutValid = s2_valid;

  // Stage 1: register the decoded fields and the box check.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_unsup <= 1'b0;
      s1_bad   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_half  <= 1'b0;
      s1_emax  <= 1'b0;
      s1_ezero <= 1'b0;
      s1_emin  <= 1'b0;
      s1_rz    <= 1'b0;
      s1_exp   <= '0;
      s1_m2    <= '0;
    end else if (InReady) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1_unsup <= ~d_ok;
        s1_bad   <= d_ok & ~d_box;
        s1_sign  <= d_sign;
        s1_half  <= d_half;
        s1_emax  <= d_emax;
        s1_ezero <= d_ezero;
        s1_emin  <= (d_ef == 15'd1);
        s1_rz    <= d_rz;
        s1_exp   <= d_exp;
        s1_m2    <= d_m2;
      end
    end
  end

  logic [4:0] lk_idx;
  logic       lk_hit, lk_bad;

  // Table lookup. Half +inf resolves to 30 via the inf path, shadowing entry 29.
  always_comb begin
    lk_idx = '0;
    lk_hit = 1'b0;
    lk_bad = 1'b0;
    if (s1_unsup) begin
      lk_hit = 1'b0;
    end else if (s1_bad) begin
      lk_idx = 5'd31; lk_hit = 1'b1; lk_bad = 1'b1;
    end else if (!s1_rz || (s1_sign && !(s1_exp == 16'sd0 && s1_m2 == 2'b00 && !s1_emax && !s1_ezero))) begin
      lk_hit = 1'b0;
    end else if (s1_sign) begin
      lk_idx = 5'd0; lk_hit = 1'b1;
    end else if (s1_emax) begin
      if (s1_m2 == 2'b00) begin
        lk_idx = 5'd30; lk_hit = 1'b1;
      end else if (s1_m2 == 2'b10) begin
        lk_idx = 5'd31; lk_hit = 1'b1;
      end
    end else if (s1_ezero) begin
      // Half-precision 2^-16 and 2^-15 are subnormal encodings.
      if (s1_half && s1_m2 == 2'b01) begin
        lk_idx = 5'd2; lk_hit = 1'b1;
      end else if (s1_half && s1_m2 == 2'b10) begin
        lk_idx = 5'd3; lk_hit = 1'b1;
      end
    end else if (s1_emin && s1_m2 == 2'b00) begin
      lk_idx = 5'd1; lk_hit = 1'b1;
    end else if (s1_m2 == 2'b00) begin
      lk_hit = 1'b1;
      case (s1_exp)
        -16'sd16: lk_idx = 5'd2;
        -16'sd15: lk_idx = 5'd3;
        -16'sd8:  lk_idx = 5'd4;
        -16'sd7:  lk_idx = 5'd5;
        -16'sd4:  lk_idx = 5'd6;
        -16'sd3:  lk_idx = 5'd7;
        -16'sd2:  lk_idx = 5'd8;
        -16'sd1:  lk_idx = 5'd12;
        16'sd0:   lk_idx = 5'd16;
        16'sd1:   lk_idx = 5'd20;
        16'sd2:   lk_idx = 5'd23;
        16'sd3:   lk_idx = 5'd24;
        16'sd4:   lk_idx = 5'd25;
        16'sd7:   lk_idx = 5'd26;
        16'sd8:   lk_idx = 5'd27;
        16'sd15:  lk_idx = 5'd28;
        16'sd16:  lk_idx = 5'd29;
        default:  lk_hit = 1'b0;
      endcase
    end else begin
      lk_hit = 1'b1;
      case (s1_exp)
        -16'sd2: lk_idx = 5'd8  + {3'b000, s1_m2};
        -16'sd1: lk_idx = 5'd12 + {3'b000, s1_m2};
        16'sd0:  lk_idx = 5'd16 + {3'b000, s1_m2};
        16'sd1: begin
          if (s1_m2 != 2'b11) lk_idx = 5'd20 + {3'b000, s1_m2};
          else                lk_hit = 1'b0;
        end
        default: lk_hit = 1'b0;
      endcase
    end
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      Idx      <= '0;
      Hit      <= 1'b0;
      BadBox   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Idx    <= lk_idx;
        Hit    <= lk_hit;
        BadBox <= lk_bad;
      end
    end
  end

endmodule

// File: tb/tb_fli_encode.sv
// Scoreboard bench for fli_encode: the driver pushes hand-computed results,
// the monitor pops and compares whenever an output is presented.
module tb_fli_encode;
  import config_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            InValid = 1'b0;
  logic            InReady;
  logic [FLEN-1:0] X = '0;
  logic [1:0]      Fmt = '0;
  logic            OutValid;
  logic            OutReady = 1'b1;
  logic [4:0]      Idx;
  logic            Hit;
  logic            BadBox;

  fli_encode dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady), .X(X), .Fmt(Fmt),
    .OutValid(OutValid), .OutReady(OutReady), .Idx(Idx), .Hit(Hit), .BadBox(BadBox)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] idx;
    logic       hit;
    logic       bad;
    int         t;
    bit         lat;
    bit         burst;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   last_burst = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called right after a negedge; returns at the negedge after the capture edge.
  task automatic send(input logic [63:0] x, input logic [1:0] f, input logic [4:0] ei,
                      input logic eh, input logic eb, input bit lat = 1'b1, input bit burst = 1'b0);
    exp_t e;
    bit   done = 1'b0;
    InValid = 1'b1;
    X = x;
    Fmt = f;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (InReady) begin
        e.idx = ei; e.hit = eh; e.bad = eb; e.t = cyc; e.lat = lat; e.burst = burst;
        q.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check("accept_timeout", 32'(InReady), 32'd1);
    InValid = 1'b0;
  endtask

  // Monitor: compares whatever is on the output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && OutValid) begin
        check("out_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q[0];
          check(OutReady ? "idx" : "idx_hold", 32'(Idx), 32'(e.idx));
          check(OutReady ? "hit" : "hit_hold", 32'(Hit), 32'(e.hit));
          check(OutReady ? "badbox" : "badbox_hold", 32'(BadBox), 32'(e.bad));
          if (OutReady) begin
            void'(q.pop_front());
            if (e.lat) check("latency", 32'(cyc - e.t), 32'd2);
            if (e.burst) begin
              if (last_burst >= 0) check("burst_gap", 32'(cyc - last_burst), 32'd1);
              last_burst = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_idx", 32'(Idx), 32'd0);
    check("rst_hit", 32'(Hit), 32'd0);
    check("rst_badbox", 32'(BadBox), 32'd0);
    check("rst_inready", 32'(InReady), 32'd1);
    @(negedge clk);

    // Single precision
    send(64'hFFFFFFFF_3F800000, 2'b00, 5'd16, 1'b1, 1'b0);
    send(64'hFFFFFFFF_3DCCCCCD, 2'b00, 5'd0,  1'b0, 1'b0);
    send(64'hFFFFFFFF_BF800000, 2'b00, 5'd0,  1'b1, 1'b0);
    send(64'hFFFFFFFF_7F800000, 2'b00, 5'd30, 1'b1, 1'b0);
    send(64'hFFFFFFFF_7FC00000, 2'b00, 5'd31, 1'b1, 1'b0);
    send(64'hFFFFFFFF_00000000, 2'b00, 5'd0,  1'b0, 1'b0);
    send(64'hFFFFFFFF_80000000, 2'b00, 5'd0,  1'b0, 1'b0);
    send(64'hFFFFFFFF_FF800000, 2'b00, 5'd0,  1'b0, 1'b0);
    send(64'hFFFFFFFF_3EA00000, 2'b00, 5'd9,  1'b1, 1'b0);
    send(64'hFFFFFFFF_47800000, 2'b00, 5'd29, 1'b1, 1'b0);
    send(64'hFFFFFFFF_00800000, 2'b00, 5'd1,  1'b1, 1'b0);
    send(64'hFFFFFFFF_37800000, 2'b00, 5'd2,  1'b1, 1'b0);
    send(64'hFFFFFFFF_40400000, 2'b00, 5'd22, 1'b1, 1'b0);
    send(64'hFFFFFFFF_40600000, 2'b00, 5'd0,  1'b0, 1'b0);
    // Double precision
    send(64'hBFF00000_00000000, 2'b01, 5'd0,  1'b1, 1'b0);
    send(64'h7FF80000_00000000, 2'b01, 5'd31, 1'b1, 1'b0);
    send(64'h7FF80000_00000001, 2'b01, 5'd0,  1'b0, 1'b0);
    send(64'h3FF00000_00000000, 2'b01, 5'd16, 1'b1, 1'b0);
    send(64'h00100000_00000000, 2'b01, 5'd1,  1'b1, 1'b0);
    send(64'h40F00000_00000000, 2'b01, 5'd29, 1'b1, 1'b0);
    send(64'h3FD40000_00000000, 2'b01, 5'd9,  1'b1, 1'b0);
    // Half precision and unsupported quad
    send(64'hFFFFFFFF_FFFF7C00, 2'b10, 5'd30, 1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFF7E00, 2'b10, 5'd31, 1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFF0400, 2'b10, 5'd1,  1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFF0100, 2'b10, 5'd2,  1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFF0200, 2'b10, 5'd3,  1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFF3C00, 2'b10, 5'd16, 1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFFBC00, 2'b10, 5'd0,  1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFF7800, 2'b10, 5'd28, 1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFF4200, 2'b10, 5'd22, 1'b1, 1'b0);
    send(64'hFFFFFFFF_FFFF3C00, 2'b11, 5'd0,  1'b0, 1'b0);
    send(64'h00000000_00000000, 2'b11, 5'd0,  1'b0, 1'b0);
    // Improper NaN boxing
    send(64'h00000000_3F800000, 2'b00, 5'd31, 1'b1, 1'b1);
    send(64'hFFFFFFFE_3F800000, 2'b00, 5'd31, 1'b1, 1'b1);
    send(64'h00000000_00003C00, 2'b10, 5'd31, 1'b1, 1'b1);
    send(64'hFFFFFFFF_7FFF3C00, 2'b10, 5'd31, 1'b1, 1'b1);
    repeat (4) @(negedge clk);

    // Backpressure: 4 operands offered while the consumer stalls for 6 cycles
    fork
      begin
        OutReady = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("stall_inready", 32'(InReady), 32'd0);
        @(negedge clk);
        OutReady = 1'b1;
      end
      begin
        send(64'hFFFFFFFF_3F800000, 2'b00, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1);
        send(64'hFFFFFFFF_40000000, 2'b00, 5'd20, 1'b1, 1'b0, 1'b0, 1'b1);
        send(64'hFFFFFFFF_41000000, 2'b00, 5'd24, 1'b1, 1'b0, 1'b0, 1'b1);
        send(64'hFFFFFFFF_43800000, 2'b00, 5'd27, 1'b1, 1'b0, 1'b0, 1'b1);
      end
    join
    repeat (4) @(negedge clk);

    // Reset with two operands in flight
    OutReady = 1'b0;
    send(64'hFFFFFFFF_3F800000, 2'b00, 5'd16, 1'b1, 1'b0, 1'b0);
    send(64'hFFFFFFFF_7FC00000, 2'b00, 5'd31, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    OutReady = 1'b1;
    #1;
    check("s6_outvalid", 32'(OutValid), 32'd0);
    check("s6_idx", 32'(Idx), 32'd0);
    check("s6_hit", 32'(Hit), 32'd0);
    check("s6_inready", 32'(InReady), 32'd1);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("s6_outvalid_after", 32'(OutValid), 32'd0);
    end
    @(negedge clk);
    send(64'hFFFFFFFF_41800000, 2'b00, 5'd25, 1'b1, 1'b0);

    for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fli_encode.md
FLI_ENCODE -- requirements
Module: fliencode

Interface
REQ-001 SHALL take these configuration constants from config_pkg (no local parameters):
- FLEN: from config_pkg; FP register width.
- ZFH_SUPPORTED: from config_pkg; half format enabled.
- D_SUPPORTED: from config_pkg; double format enabled.
- Q_SUPPORTED: from config_pkg; quad format enabled.

REQ-002 SHALL have exactly these ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- InValid  in  1  input operand valid.
- InReady  out  1  block can accept an operand.
- X  in  FLEN  FP register value, NaN-boxed.
- Fmt  in  2  format: 00 single, 01 double, 10 half, 11 quad.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- Idx  out  5  FLI index (the Rs1 encoding).
- Hit  out  1  X is exactly representable by fli.fmt.
- BadBox  out  1  X was improperly NaN-boxed for Fmt.

REQ-003 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-004 SHALL be the inverse of FP immediate load: given X and Fmt, return the Rs1 index i such that fli.fmt with index i writes X.
REQ-005 SHALL set Hit=1 and Idx=i iff the Fmt-width value is bit-identical to entry i of the Zfa fli table for that format. Example single entries: 0=BF800000, 16=3F800000, 30=7F800000, 31=7FC00000.
REQ-006 For half, entries 29 and 30 are both 7C00; SHALL return Idx=30.
REQ-007 On a miss, SHALL output Hit=0, Idx=0. This includes +0, -0, non-canonical NaNs and every non-table value.
REQ-008 NaN-box check: for Fmt narrower than FLEN, if X[FLEN-1:width] is not all ones, the operand SHALL be treated as canonical NaN: Hit=1, Idx=31, BadBox=1. Otherwise BadBox=0.
REQ-009 Fmt selecting an unsupported format (Zfh/D/Q off, or width > FLEN) SHALL give Hit=0, Idx=0, BadBox=0.
REQ-010 SHALL be a 2-stage pipeline:
- Stage 1 registers sign, exponent, mantissa-zero flags and the box check.
- Stage 2 registers Idx/Hit/BadBox.
- Latency: an input accepted at edge N appears with OutValid=1 after edge N+2, provided there is no backpressure.
REQ-011 Handshake:
- Input transfer occurs when InValid&InReady.
- Output transfer occurs when OutValid&OutReady.
- Throughput is one result per cycle when OutReady=1.
REQ-012 Stage advance and stall:
- Stage 2 loads when it is empty or is transferring.
- Stage 1 advances only when stage 2 loads.
- InReady = ~S1Valid | stage-1 advance; InReady is combinational from OutReady.
REQ-013 While OutValid=1 and OutReady=0, Idx/Hit/BadBox SHALL hold stable.
REQ-014 Results SHALL leave in acceptance order; none are dropped or duplicated. Capacity is 2 outstanding.
REQ-015 Simultaneous output transfer and input transfer on one edge with a full pipe SHALL shift both stages without a bubble.
REQ-016 X and Fmt SHALL be ignored when InValid=0. No state changes except through a transfer.

Reset
REQ-017 On reset the block SHALL:
- clear both stage valids;
- drive OutValid=0, Idx=0, Hit=0, BadBox=0;
- drive InReady=1 in the cycle after reset deasserts.
REQ-018 Reset asserted mid-operation SHALL discard in-flight operands. No OutValid occurs for them.

Verification
REQ-019 Bench configuration: FLEN=64, ZFH_SUPPORTED=1, D_SUPPORTED=1, Q_SUPPORTED=0. Scenarios:
- S1: X=FFFFFFFF_3F800000, Fmt=00, OutReady=1 -> 2 cycles later OutValid=1, Idx=16, Hit=1, BadBox=0. Also X=FFFFFFFF_3DCCCCCD -> Hit=0, Idx=0.
- S2: X=BFF0000000000000, Fmt=01 -> Idx=0, Hit=1. X=7FF8000000000000 -> Idx=31. X=7FF8000000000001 -> Hit=0.
- S3: Fmt=10 with X=FFFFFFFFFFFF7C00 -> Idx=30. X=...7E00 -> Idx=31. X=...0400 -> Idx=1. Fmt=11 (unsupported) -> Hit=0, Idx=0.
- S4: X=00000000_3F800000, Fmt=00 -> Hit=1, Idx=31, BadBox=1.
- S5: OutReady=0 for 6 cycles while 4 operands are offered -> InReady drops after 2 accepted, outputs hold stable. Then OutReady=1 -> results emerge in order, one per cycle.
- S6: 2 operands in flight, reset pulsed for 1 cycle -> OutValid=0 throughout and after; the next operand gives correct Idx after 2 cycles.
